// File: rtl/rr_sel8x2_if.sv
// ---------------------------------------------------------------------------
// rr_sel8x2_if
// Bundles the request vectors and registered select/grant outputs of the
// dual 8-way round-robin arbiter.
//
//   req0, req1         : per-channel request vectors (bit i = requestor i)
//   sel0, sel1         : registered 3-bit select indices to the dual 8:1 mux
//   gnt0, gnt1         : registered one-hot grants
//   gnt_vld0, gnt_vld1 : grant-active flags
//
// master : requestor side (drives req, observes grants)
// slave  : arbiter side (observes req, drives sel/gnt/gnt_vld)
// ---------------------------------------------------------------------------
interface rr_sel8x2_if;
  logic [7:0] req0;
  logic [7:0] req1;
  logic [2:0] sel0;
  logic [2:0] sel1;
  logic [7:0] gnt0;
  logic [7:0] gnt1;
  logic       gnt_vld0;
  logic       gnt_vld1;

  modport master (
    output req0, req1,
    input  sel0, sel1, gnt0, gnt1, gnt_vld0, gnt_vld1
  );

  modport slave (
    input  req0, req1,
    output sel0, sel1, gnt0, gnt1, gnt_vld0, gnt_vld1
  );
endinterface

// File: rtl/rr_sel8x2.sv
// ---------------------------------------------------------------------------
// rr_sel8x2
// Dual independent 8-way round-robin arbiter producing the registered select
// pairs for a downstream dual 8:1 mux slice. Each channel grants one of eight
// requestors, holds that grant for at most MAX_HOLD consecutive cycles while
// the requestor keeps asking, then rotates. Selects hold their last value while
// idle so the mux output does not change between grants.
//
// rr_sel8x2_ch (one arbiter channel)
//   clk      in   core clock, rising edge
//   reset_n  in   synchronous active-low reset
//   req_i    in   8-bit request vector
//   sel_o    out  registered select index
//   gnt_o    out  registered one-hot grant
//   vld_o    out  grant active
//
// rr_sel8x2 (top)
//   clk      in   core clock, rising edge
//   reset_n  in   synchronous active-low reset
//   bus      slave modport of rr_sel8x2_if (req0/1 in; sel/gnt/gnt_vld 0/1 out)
//
// Parameters
//   MAX_HOLD : max consecutive cycles a grant may be held (1..256)
//   HCW      : hold-counter width, 2**HCW >= MAX_HOLD
// ---------------------------------------------------------------------------
module rr_sel8x2_ch #(
  parameter int MAX_HOLD = 4,
  parameter int HCW      = 8
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [7:0] req_i,
  output logic [2:0] sel_o,
  output logic [7:0] gnt_o,
  output logic       vld_o
);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

  // hcnt counts completed extra cycles of the current grant; reaching this
  // value means the grant has lasted MAX_HOLD cycles.
  localparam logic [HCW-1:0] HOLD_LAST = HCW'(MAX_HOLD - 1);

  state_t         st_q,   st_d;
  logic [2:0]     ptr_q,  ptr_d;
  logic [HCW-1:0] hcnt_q, hcnt_d;
  logic [2:0]     sel_q,  sel_d;
  logic [7:0]     gnt_q,  gnt_d;
  logic           vld_q,  vld_d;

  logic [3:0]     pick;
  logic           hit;
  logic [2:0]     pidx;

  // Returns {found, index} of the first set request scanning ptr, ptr+1, ...
  // ptr+7 (mod 8). Scanning from the far end lets the nearest hit win.
  function automatic logic [3:0] pick_f(input logic [7:0] req,
                                        input logic [2:0] ptr);
    logic [3:0] res;
    logic [2:0] idx;
    res = 4'd0;
    for (int k = 7; k >= 0; k--) begin
      idx = ptr + 3'(k);
      if (req[idx]) res = {1'b1, idx};
    end
    return res;
  endfunction

  // The pointer is advanced past the current grant at grant start, so at the
  // end of a grant the holder is scanned last and only wins when alone.
  assign pick = pick_f(req_i, ptr_q);
  assign hit  = pick[3];
  assign pidx = pick[2:0];

  always_comb begin
    st_d   = st_q;
    ptr_d  = ptr_q;
    hcnt_d = hcnt_q;
    sel_d  = sel_q;
    gnt_d  = gnt_q;
    vld_d  = vld_q;

    unique case (st_q)
      ST_IDLE: begin
        gnt_d = 8'h00;
        vld_d = 1'b0;
        if (hit) begin
          st_d   = ST_GRANT;
          sel_d  = pidx;
          gnt_d  = 8'h01 << pidx;
          vld_d  = 1'b1;
          hcnt_d = '0;
          ptr_d  = pidx + 3'd1;
        end
      end

      ST_GRANT: begin
        if (req_i[sel_q] && (hcnt_q < HOLD_LAST)) begin
          hcnt_d = hcnt_q + 1'b1;
        end else if (hit) begin
          // Back-to-back handover, no idle bubble.
          sel_d  = pidx;
          gnt_d  = 8'h01 << pidx;
          vld_d  = 1'b1;
          hcnt_d = '0;
          ptr_d  = pidx + 3'd1;
        end else begin
          // sel keeps the last holder so the mux output stays put.
          st_d  = ST_IDLE;
          gnt_d = 8'h00;
          vld_d = 1'b0;
        end
      end

      default: begin
        st_d  = ST_IDLE;
        gnt_d = 8'h00;
        vld_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      st_q   <= ST_IDLE;
      ptr_q  <= 3'd0;
      hcnt_q <= '0;
      sel_q  <= 3'd0;
      gnt_q  <= 8'h00;
      vld_q  <= 1'b0;
    end else begin
      st_q   <= st_d;
      ptr_q  <= ptr_d;
      hcnt_q <= hcnt_d;
      sel_q  <= sel_d;
      gnt_q  <= gnt_d;
      vld_q  <= vld_d;
    end
  end

  assign sel_o = sel_q;
  assign gnt_o = gnt_q;
  assign vld_o = vld_q;

endmodule

module rr_sel8x2 #(
  parameter int MAX_HOLD = 4,
  parameter int HCW      = 8
) (
  input logic        clk,
  input logic        reset_n,
  rr_sel8x2_if.slave bus
);

  // Two identical channels with no shared state.
  rr_sel8x2_ch #(
    .MAX_HOLD (MAX_HOLD),
    .HCW      (HCW)
  ) u_ch0 (
    .clk     (clk),
    .reset_n (reset_n),
    .req_i   (bus.req0),
    .sel_o   (bus.sel0),
    .gnt_o   (bus.gnt0),
    .vld_o   (bus.gnt_vld0)
  );

  rr_sel8x2_ch #(
    .MAX_HOLD (MAX_HOLD),
    .HCW      (HCW)
  ) u_ch1 (
    .clk     (clk),
    .reset_n (reset_n),
    .req_i   (bus.req1),
    .sel_o   (bus.sel1),
    .gnt_o   (bus.gnt1),
    .vld_o   (bus.gnt_vld1)
  );

endmodule

// File: tb/tb_rr_sel8x2.sv
// ---------------------------------------------------------------------------
// tb_rr_sel8x2
// Directed bench for rr_sel8x2. Instance dut uses MAX_HOLD=4, instance dut1
// uses MAX_HOLD=1; both share clock and reset.
// ---------------------------------------------------------------------------
module tb_rr_sel8x2;

  logic clk;
  logic reset_n;

  int nvec;
  int nerr;

  rr_sel8x2_if bus ();
  rr_sel8x2_if bus1 ();

  rr_sel8x2 #(.MAX_HOLD(4), .HCW(8)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  rr_sel8x2 #(.MAX_HOLD(1), .HCW(8)) dut1 (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus1.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs,
                     input logic [7:0] exp);
    nvec++;
    assert (obs === exp)
    else begin
      nerr++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  logic [7:0] exp_hold [9];
  logic [7:0] one_hot;

  initial begin
    nvec = 0;
    nerr = 0;
    exp_hold = '{8'h01, 8'h01, 8'h01, 8'h01, 8'h04, 8'h04, 8'h04, 8'h04, 8'h01};

    // Reset held with every request asserted.
    reset_n   = 1'b0;
    bus.req0  = 8'hFF;
    bus.req1  = 8'hFF;
    bus1.req0 = 8'h00;
    bus1.req1 = 8'h00;
    tick();
    tick();
    chk("rst_sel0", {5'd0, bus.sel0}, 8'h00);
    chk("rst_sel1", {5'd0, bus.sel1}, 8'h00);
    chk("rst_gnt0", bus.gnt0, 8'h00);
    chk("rst_gnt1", bus.gnt1, 8'h00);
    chk("rst_vld0", {7'd0, bus.gnt_vld0}, 8'h00);
    chk("rst_vld1", {7'd0, bus.gnt_vld1}, 8'h00);

    // First grant one cycle after release.
    reset_n = 1'b1;
    tick();
    chk("rel_gnt0", bus.gnt0, 8'h01);
    chk("rel_gnt1", bus.gnt1, 8'h01);
    chk("rel_sel0", {5'd0, bus.sel0}, 8'h00);
    chk("rel_vld1", {7'd0, bus.gnt_vld1}, 8'h01);

    bus.req0 = 8'h00;
    bus.req1 = 8'h00;
    tick();
    chk("idle_vld0", {7'd0, bus.gnt_vld0}, 8'h00);
    chk("idle_gnt1", bus.gnt1, 8'h00);

    // Hold cap: two constant requestors alternate in bursts of four.
    reset_n = 1'b0;
    tick();
    reset_n  = 1'b1;
    bus.req0 = 8'h05;
    for (int i = 0; i < 9; i++) begin
      tick();
      chk($sformatf("hold_gnt0[%0d]", i), bus.gnt0, exp_hold[i]);
      chk($sformatf("hold_vld0[%0d]", i), {7'd0, bus.gnt_vld0}, 8'h01);
    end
    bus.req0 = 8'h00;
    tick();
    chk("hold_end_vld0", {7'd0, bus.gnt_vld0}, 8'h00);

    // Early release: requestor 1 asks for two cycles then drops.
    bus.req0 = 8'h02;
    tick();
    chk("early_gnt0_a", bus.gnt0, 8'h02);
    tick();
    chk("early_gnt0_b", bus.gnt0, 8'h02);
    bus.req0 = 8'h00;
    tick();
    chk("early_vld0", {7'd0, bus.gnt_vld0}, 8'h00);
    chk("early_gnt0", bus.gnt0, 8'h00);
    chk("early_sel0", {5'd0, bus.sel0}, 8'h01);

    // Wrap: grant index 6 to park ptr at 7, then 0 must beat 6.
    bus.req0 = 8'h40;
    tick();
    chk("wrap_pre_gnt0", bus.gnt0, 8'h40);
    bus.req0 = 8'h00;
    tick();
    chk("wrap_pre_idle", {7'd0, bus.gnt_vld0}, 8'h00);
    bus.req0 = 8'h41;
    tick();
    chk("wrap_gnt0", bus.gnt0, 8'h01);
    chk("wrap_sel0", {5'd0, bus.sel0}, 8'h00);
    bus.req0 = 8'h40;
    tick();
    chk("wrap_next_gnt0", bus.gnt0, 8'h40);
    chk("wrap_next_sel0", {5'd0, bus.sel0}, 8'h06);
    bus.req0 = 8'h00;
    tick();
    chk("wrap_idle_sel0", {5'd0, bus.sel0}, 8'h06);

    // Independence plus reset mid-burst.
    bus.req0 = 8'h80;
    bus.req1 = 8'h01;
    tick();
    chk("ind_sel0", {5'd0, bus.sel0}, 8'h07);
    chk("ind_sel1", {5'd0, bus.sel1}, 8'h00);
    chk("ind_gnt0", bus.gnt0, 8'h80);
    chk("ind_gnt1", bus.gnt1, 8'h01);
    tick();
    chk("ind_hold_gnt0", bus.gnt0, 8'h80);
    reset_n = 1'b0;
    tick();
    chk("ind_rst_vld0", {7'd0, bus.gnt_vld0}, 8'h00);
    chk("ind_rst_vld1", {7'd0, bus.gnt_vld1}, 8'h00);
    chk("ind_rst_sel0", {5'd0, bus.sel0}, 8'h00);
    chk("ind_rst_gnt1", bus.gnt1, 8'h00);
    reset_n  = 1'b1;
    bus.req0 = 8'h00;
    bus.req1 = 8'h00;
    tick();

    // MAX_HOLD=1: all requestors active rotate one per cycle.
    bus1.req1 = 8'hFF;
    for (int i = 0; i < 9; i++) begin
      tick();
      one_hot = 8'h01 << (i % 8);
      chk($sformatf("mh1_sel1[%0d]", i), {5'd0, bus1.sel1}, 8'(i % 8));
      chk($sformatf("mh1_gnt1[%0d]", i), bus1.gnt1, one_hot);
      chk($sformatf("mh1_vld1[%0d]", i), {7'd0, bus1.gnt_vld1}, 8'h01);
    end
    chk("mh1_ch0_idle", bus1.gnt0, 8'h00);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
